// File: rtl/gmii_eth_tx.sv
// GMII Ethernet frame transmitter: preamble, SFD, payload, pad, FCS, IFG.
// Optional zero-padding of short frames is enabled by GMII_TX_PAD_EN.
module gmii_eth_tx #(
    parameter int LEN_W      = 11,
    parameter int MIN_FRAME  = 60,
    parameter int IFG_CYCLES = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_start,
    input  logic [LEN_W-1:0] tx_len,
    input  logic [7:0]       tx_data,
    output logic             data_req,
    output logic             crc_clr,
    output logic             crc_en,
    output logic [7:0]       crc_din,
    input  logic [31:0]      crc_data,
    output logic             gmii_tx_en,
    output logic [7:0]       gmii_txd,
    output logic             tx_busy,
    output logic             tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
`ifdef GMII_TX_PAD_EN
        PAD,
`endif
        FCS,
        IFG
    } state_t;

    // state names what is currently on the wire; outputs are loaded from state_n
    state_t           state, state_n, after_data;
    logic [LEN_W-1:0] cnt, cnt_n, len_q, len_n, after_cnt;
    logic [7:0]       txd_n;
    logic             en_n;
    logic [31:0]      crc_rev;

`ifdef GMII_TX_PAD_EN
    // pad continues the body count so PAD ends at MIN_FRAME-1
    always_comb begin
        after_data = FCS;
        after_cnt  = '0;
        if (len_q < LEN_W'(MIN_FRAME)) begin
            after_data = PAD;
            after_cnt  = len_q;
        end
    end
`else
    assign after_data = FCS;
    assign after_cnt  = '0;
`endif

    always_comb begin
        for (int j = 0; j < 32; j++) crc_rev[j] = crc_data[31-j];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            len_q      <= '0;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            len_q      <= len_n;
            gmii_tx_en <= en_n;
            gmii_txd   <= txd_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        len_n   = len_q;
        case (state)
            IDLE: begin
                if (tx_start) begin
                    state_n = PRE;
                    cnt_n   = '0;
                    len_n   = tx_len;
                end
            end
            PRE: begin
                if (cnt == LEN_W'(6)) begin
                    state_n = SFD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + LEN_W'(1);
                end
            end
            SFD: begin
                if (len_q != '0) begin
                    state_n = DATA;
                    cnt_n   = '0;
                end else begin
                    state_n = after_data;
                    cnt_n   = after_cnt;
                end
            end
            DATA: begin
                if (cnt == len_q - LEN_W'(1)) begin
                    state_n = after_data;
                    cnt_n   = after_cnt;
                end else begin
                    cnt_n = cnt + LEN_W'(1);
                end
            end
`ifdef GMII_TX_PAD_EN
            PAD: begin
                if (cnt == LEN_W'(MIN_FRAME - 1)) begin
                    state_n = FCS;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + LEN_W'(1);
                end
            end
`endif
            FCS: begin
                if (cnt == LEN_W'(3)) begin
                    state_n = IFG;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + LEN_W'(1);
                end
            end
            IFG: begin
                if (cnt == LEN_W'(IFG_CYCLES - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + LEN_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        en_n     = 1'b0;
        txd_n    = 8'h00;
        data_req = 1'b0;
        crc_clr  = 1'b0;
        crc_en   = 1'b0;
        crc_din  = 8'h00;
        case (state_n)
            PRE: begin
                en_n  = 1'b1;
                txd_n = 8'h55;
            end
            SFD: begin
                en_n    = 1'b1;
                txd_n   = 8'hD5;
                crc_clr = 1'b1;
            end
            DATA: begin
                en_n     = 1'b1;
                txd_n    = tx_data;
                data_req = 1'b1;
                crc_en   = 1'b1;
                crc_din  = tx_data;
            end
`ifdef GMII_TX_PAD_EN
            PAD: begin
                en_n   = 1'b1;
                crc_en = 1'b1;
            end
`endif
            FCS: begin
                // FCS byte k is the complemented, bit-reversed CRC byte k
                en_n  = 1'b1;
                txd_n = ~crc_rev[8*cnt_n[1:0] +: 8];
            end
            default: ;
        endcase
    end

    assign tx_busy = (state != IDLE);
    assign tx_done = (state == IFG) && (cnt == LEN_W'(IFG_CYCLES - 1));

endmodule

// File: doc/gmii_eth_tx.md
Name: gmii_eth_tx

Overview:
GMII Ethernet frame transmitter that sits directly upstream of the byte-wide CRC32 stage.
- Builds each frame on the wire: preamble, SFD, payload, optional pad, FCS, inter-frame gap.
- Drives the CRC stage's clear/enable/data inputs and reads its registered CRC value back to append the 4-byte FCS.
- Payload bytes come from an upstream UDP/IP frame builder through a pull-style request interface.

Parameters:
- LEN_W, 11, width of tx_len (max frame body 2047 bytes).
- MIN_FRAME, 60, minimum frame body in bytes (DA through payload, excluding FCS).
- IFG_CYCLES, 12, idle cycles enforced after the last FCS byte.

Ports:
- clk  in  1  GMII TX clock (125 MHz).
- rst  in  1  reset, asynchronous, active-high.
- tx_start  in  1  one-cycle frame request; ignored while tx_busy=1.
- tx_len  in  LEN_W  frame body length in bytes, sampled when tx_start is accepted.
- tx_data  in  8  current payload byte, valid whenever data_req=1 (first-word-fall-through).
- data_req  out  1  block consumes tx_data this cycle; upstream advances on the same edge.
- crc_clr  out  1  to CRC stage: reload 0xFFFFFFFF.
- crc_en  out  1  to CRC stage: fold crc_din this cycle.
- crc_din  out  8  to CRC stage: the byte being loaded into gmii_txd this cycle.
- crc_data  in  32  from CRC stage: registered CRC value.
- gmii_tx_en  out  1  GMII transmit enable.
- gmii_txd  out  8  GMII transmit data.
- tx_busy  out  1  high from accepted tx_start until the end of the IFG.
- tx_done  out  1  one-cycle pulse on the last IFG cycle.

Behaviour:
- Reset values: every output = 0. FSM = IDLE, counters = 0. Reset mid-frame aborts at once: tx_en drops, no FCS is sent, no tx_done pulse.
- All GMII outputs are registered. crc_clr, crc_en, crc_din and data_req are combinational from state and counters.
- FSM states: IDLE -> PRE -> SFD -> DATA -> PAD -> FCS -> IFG -> IDLE.
- IDLE:
  - tx_start=1 latches tx_len, sets tx_busy and goes to PRE.
  - gmii_tx_en rises on the next edge, so latency from tx_start to first 0x55 on the wire is 1 cycle.
- PRE: 7 cycles of gmii_txd=0x55.
- SFD:
  - 1 cycle of gmii_txd=0xD5.
  - crc_clr=1 during the cycle that loads SFD, so the CRC register holds 0xFFFFFFFF before the first DATA byte.
- DATA:
  - tx_len cycles with data_req=1, gmii_txd<=tx_data, crc_en=1, crc_din=tx_data.
  - tx_len=0 skips DATA entirely.
- PAD: entered when tx_len < MIN_FRAME; emits (MIN_FRAME - tx_len) bytes of 0x00 with crc_en=1, crc_din=0x00. Otherwise skipped.
- FCS:
  - 4 cycles, crc_en=0, so crc_data is stable.
  - Byte k (k=0..3) = bitwise NOT of the bit-reversed crc_data[31-8k:24-8k], i.e. byte k bit i = ~crc_data[31-8k-i].
  - gmii_tx_en stays high through the last FCS byte.
- IFG: gmii_tx_en=0, gmii_txd=0x00 for IFG_CYCLES cycles. tx_done=1 on the final IFG cycle. tx_busy drops with the return to IDLE.
- Frame on wire (pad on) = 8 + max(tx_len, MIN_FRAME) + 4 consecutive tx_en cycles, with no gaps.
- A tx_start during busy, including the tx_done cycle, is dropped. A tx_start in the first IDLE cycle after tx_busy falls is accepted.
- data_req is never asserted outside DATA. Upstream must always have a byte ready when data_req=1; there is no backpressure mid-frame.

Optional Feature:
- Macro: GMII_TX_PAD_EN.
- Defined: short frames are zero-padded to MIN_FRAME as above.
- Undefined: PAD state is removed. Frames go out at exactly tx_len bytes plus FCS, with the FCS computed over tx_len bytes only.

Test Plan:
- Pad off: tx_len=9, bytes "123456789" (0x31..0x39) -> wire shows 7x0x55, 0xD5, 0x31..0x39, then FCS 0x26,0x39,0xF4,0xCB; tx_en high for exactly 21 cycles.
- Pad on: tx_len=9 -> tx_en high 72 cycles; bytes 18..68 of the frame = 0x00; FCS matches a software CRC32 over the 60-byte body; data_req high exactly 9 cycles.
- tx_len=1514, incrementing bytes -> 1526 tx_en cycles, no pad; tx_done 12 cycles after tx_en falls; back-to-back tx_start in the next IDLE cycle starts a new preamble 1 cycle later.
- tx_start pulsed in the middle of DATA and on the tx_done cycle -> both ignored; only one frame appears on the wire.
- rst asserted at DATA byte 20 -> outputs 0 that same cycle (async); after release, tx_start with tx_len=60 produces a clean 72-cycle frame with a correct FCS.
- tx_len=0, pad on -> 60 bytes of 0x00 and FCS; data_req never asserted.
